reg_scoreboard: RTL and testbench

- Hazard scoreboard sitting between the decode stage and the register file.
- Tracks destination registers with writes in flight (claimed at issue from ID, released at writeback) and drives the register-access grant the decode stage waits on before handing an instruction to EX.
- Stalls ID on read-after-write hazards, per-register counter saturation and in-flight limit; supports pipeline flush.

---
 rtl/reg_scoreboard.sv | 101 ++++++++++
 tb/tb_reg_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard between decode and the register file.
// Counts in-flight writes per architectural register (x1..x31) and grants
// decode access only when no source is pending, the destination counter has
// headroom and the global in-flight budget allows another claim.
module reg_scoreboard #(
  parameter int MAX_INFLIGHT   = 4,
  parameter int CNT_W          = 2,
  parameter int BYPASS_RELEASE = 1
) (
  input  logic                                clk,
  input  logic                                resetn_i,
  input  logic                                ID_SB_req_i,
  input  logic [4:0]                          ID_SB_rs1_i,
  input  logic [4:0]                          ID_SB_rs2_i,
  input  logic                                ID_SB_rs1_used_i,
  input  logic                                ID_SB_rs2_used_i,
  input  logic [4:0]                          ID_SB_rd_i,
  input  logic                                ID_SB_rd_valid_i,
  output logic                                SB_ID_access_o,
  input  logic                                WB_SB_release_i,
  input  logic [4:0]                          WB_SB_rd_i,
  input  logic                                flush_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   SB_inflight_o,
  output logic                                SB_err_o
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0]    IF_ONE  = IW'(1);
  localparam logic [IW-1:0]    IF_MAX  = IW'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // pend[0] stays zero forever so x0 never appears busy
  logic [CNT_W-1:0] pend [32];
  logic [IW-1:0]    inflight;
  logic             err;

  logic rs1_haz, rs2_haz;
  logic rs1_byp, rs2_byp;
  logic wants_claim, room_ok, cnt_ok;
  logic grant, claim, rel, rel_nz, same_reg;
  logic [8:0] pend_sum;

  // Source hazards; a release of the last pending write may bypass the stall
  always_comb begin
    rs1_byp = (BYPASS_RELEASE != 0) && WB_SB_release_i &&
              (WB_SB_rd_i == ID_SB_rs1_i) && (pend[ID_SB_rs1_i] == CNT_ONE);
    rs2_byp = (BYPASS_RELEASE != 0) && WB_SB_release_i &&
              (WB_SB_rd_i == ID_SB_rs2_i) && (pend[ID_SB_rs2_i] == CNT_ONE);
    rs1_haz = ID_SB_rs1_used_i && (ID_SB_rs1_i != 5'd0) &&
              (pend[ID_SB_rs1_i] != '0) && !rs1_byp;
    rs2_haz = ID_SB_rs2_used_i && (ID_SB_rs2_i != 5'd0) &&
              (pend[ID_SB_rs2_i] != '0) && !rs2_byp;
  end

  // Grant decision; budget checks use registered state only
  always_comb begin
    wants_claim = ID_SB_rd_valid_i && (ID_SB_rd_i != 5'd0);
    room_ok     = (inflight < IF_MAX) || !wants_claim;
    cnt_ok      = (pend[ID_SB_rd_i] != CNT_MAX) || !wants_claim;
    grant       = resetn_i && ID_SB_req_i && !flush_i && !rs1_haz && !rs2_haz &&
                  room_ok && cnt_ok;
    claim       = grant && wants_claim;
    rel         = WB_SB_release_i && (WB_SB_rd_i != 5'd0);
    rel_nz      = pend[WB_SB_rd_i] != '0;
    same_reg    = claim && rel && (ID_SB_rd_i == WB_SB_rd_i);
  end

  assign SB_ID_access_o = grant;
  assign SB_inflight_o  = inflight;
  assign SB_err_o       = err;

  // Pending counters, in-flight total and sticky error; same-register
  // claim/release pairs cancel and never flag an error
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
      inflight <= '0;
    end else if (!same_reg) begin
      if (claim) pend[ID_SB_rd_i] <= pend[ID_SB_rd_i] + CNT_ONE;
      if (rel && rel_nz) pend[WB_SB_rd_i] <= pend[WB_SB_rd_i] - CNT_ONE;
      if (rel && !rel_nz) err <= 1'b1;
      if (claim && !(rel && rel_nz)) inflight <= inflight + IF_ONE;
      else if (!claim && rel && rel_nz) inflight <= inflight - IF_ONE;
    end
  end

  // Sum of per-register counters, used only by the consistency check
  always_comb begin
    pend_sum = '0;
    for (int i = 1; i < 32; i++) pend_sum = pend_sum + 9'(pend[i]);
  end

  a_inflight_consistent: assert property (@(posedge clk) disable iff (!resetn_i)
    (pend_sum == 9'(inflight)) && (inflight <= IF_MAX));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one instance with release bypass and
// one without, sharing all inputs.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       resetn_i;
  logic       req, rs1_used, rs2_used, rd_valid, wb_rel, flush;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic       gnt, gnt_nb, err, err_nb;
  logic [2:0] infl, infl_nb;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(2), .BYPASS_RELEASE(1)) u_dut (
    .clk(clk), .resetn_i(resetn_i),
    .ID_SB_req_i(req), .ID_SB_rs1_i(rs1), .ID_SB_rs2_i(rs2),
    .ID_SB_rs1_used_i(rs1_used), .ID_SB_rs2_used_i(rs2_used),
    .ID_SB_rd_i(rd), .ID_SB_rd_valid_i(rd_valid), .SB_ID_access_o(gnt),
    .WB_SB_release_i(wb_rel), .WB_SB_rd_i(wb_rd), .flush_i(flush),
    .SB_inflight_o(infl), .SB_err_o(err)
  );

  reg_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(2), .BYPASS_RELEASE(0)) u_dut_nb (
    .clk(clk), .resetn_i(resetn_i),
    .ID_SB_req_i(req), .ID_SB_rs1_i(rs1), .ID_SB_rs2_i(rs2),
    .ID_SB_rs1_used_i(rs1_used), .ID_SB_rs2_used_i(rs2_used),
    .ID_SB_rd_i(rd), .ID_SB_rd_valid_i(rd_valid), .SB_ID_access_o(gnt_nb),
    .WB_SB_release_i(wb_rel), .WB_SB_rd_i(wb_rd), .flush_i(flush),
    .SB_inflight_o(infl_nb), .SB_err_o(err_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_valid = 0; wb_rel = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic claim(input logic [4:0] r);
    idle();
    req = 1; rd = r; rd_valid = 1;
    #1 chk("claim_gnt", gnt, 1);
    cyc();
    idle();
  endtask

  task automatic rel(input logic [4:0] r);
    idle();
    wb_rel = 1; wb_rd = r;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    resetn_i = 0;
    req = 1; rd = 7; rd_valid = 1;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_infl", infl, 0);
    chk("rst_err", err, 0);
    #1 resetn_i = 1;
    idle();
    cyc();

    // basic claim, no hazards
    req = 1; rs1 = 5; rs2 = 6; rs1_used = 1; rs2_used = 1; rd = 7; rd_valid = 1;
    #1 chk("t1_gnt", gnt, 1);
    chk("t1_gnt_nb", gnt_nb, 1);
    cyc();
    idle();
    chk("t1_infl", infl, 1);
    chk("t1_infl_nb", infl_nb, 1);

    // RAW hazard and release bypass
    req = 1; rs1 = 7; rs1_used = 1;
    #1 chk("raw_stall", gnt, 0);
    chk("raw_stall_nb", gnt_nb, 0);
    wb_rel = 1; wb_rd = 7;
    #1 chk("byp_gnt", gnt, 1);
    chk("nobyp_gnt", gnt_nb, 0);
    cyc();
    wb_rel = 0;
    #1 chk("nobyp_next", gnt_nb, 1);
    chk("rel_infl", infl, 0);
    chk("rel_infl_nb", infl_nb, 0);
    idle();

    // in-flight limit
    for (int i = 1; i <= 4; i++) claim(5'(i));
    chk("lim_infl", infl, 4);
    req = 1; rd = 8; rd_valid = 1;
    #1 chk("lim_stall", gnt, 0);
    wb_rel = 1; wb_rd = 1;
    #1 chk("lim_stall_rel", gnt, 0);
    wb_rel = 0; rd_valid = 0;
    #1 chk("lim_norv", gnt, 1);
    rd_valid = 1; rd = 0;
    #1 chk("lim_rd0", gnt, 1);
    cyc();
    idle();
    chk("lim_hold", infl, 4);
    for (int i = 1; i <= 4; i++) rel(5'(i));
    chk("lim_drain", infl, 0);

    // per-register counter saturation
    for (int i = 0; i < 3; i++) claim(5'd9);
    chk("sat_infl", infl, 3);
    req = 1; rd = 9; rd_valid = 1;
    #1 chk("cnt_sat", gnt, 0);
    wb_rel = 1; wb_rd = 9;
    #1 chk("cnt_sat_rel", gnt, 0);
    cyc();
    wb_rel = 0;
    #1 chk("cnt_after", gnt, 1);
    chk("cnt_after_infl", infl, 2);
    cyc();
    idle();
    chk("cnt_reclaim", infl, 3);
    for (int i = 0; i < 3; i++) rel(5'd9);
    chk("cnt_drain", infl, 0);

    // same-cycle claim and release of one register
    claim(5'd10);
    req = 1; rd = 10; rd_valid = 1; wb_rel = 1; wb_rd = 10;
    #1 chk("same_gnt", gnt, 1);
    cyc();
    idle();
    chk("same_infl", infl, 1);
    rel(5'd10);
    chk("same_drain", infl, 0);
    req = 1; rd = 11; rd_valid = 1; wb_rel = 1; wb_rd = 11;
    cyc();
    idle();
    chk("same_zero_infl", infl, 0);
    chk("same_zero_err", err, 0);

    // release errors
    rel(5'd0);
    chk("rel_x0_err", err, 0);
    rel(5'd12);
    chk("rel_zero_err", err, 1);
    chk("rel_zero_infl", infl, 0);
    cyc();
    chk("err_sticky", err, 1);

    // flush
    claim(5'd13);
    claim(5'd14);
    claim(5'd15);
    chk("pre_flush_infl", infl, 3);
    flush = 1; req = 1; rd = 16; rd_valid = 1; wb_rel = 1; wb_rd = 13;
    #1 chk("flush_gnt", gnt, 0);
    cyc();
    idle();
    chk("flush_infl", infl, 0);
    chk("flush_err", err, 1);
    req = 1; rs1 = 13; rs1_used = 1; rs2 = 14; rs2_used = 1;
    #1 chk("flush_pend", gnt, 1);
    idle();
    cyc();

    // reset in the middle of operation
    claim(5'd13);
    claim(5'd14);
    chk("pre_rst_infl", infl, 2);
    req = 1; rd = 15; rd_valid = 1;
    #1 chk("pre_rst_gnt", gnt, 1);
    #2 resetn_i = 0;
    #1 chk("mid_rst_infl", infl, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_gnt", gnt, 0);
    #2 resetn_i = 1;
    idle();
    req = 1; rs1 = 13; rs1_used = 1; rs2 = 14; rs2_used = 1;
    #1 chk("post_rst_gnt", gnt, 1);
    cyc();
    idle();
    chk("post_rst_infl", infl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
